// File: rtl/sw_reg_loader_if.sv
// sw_reg_loader_if
// Board-side bundle for the switch/key register loader.
//   sw     : {channel select, data} from the slide switches
//   key    : active-low pushbuttons, [0]=load [1]=inc [2]=dec
//   q      : packed channel registers, channel i = q[i*DW +: DW]
//   upd    : one-cycle pulse, a channel was modified
//   upd_ch : index of the last modified channel (held)
//   err    : one-cycle pulse, press with an out-of-range selector
// Pulse semantics: upd and err are single-cycle strobes with no
// back-pressure. A consumer samples them on the clock edge after they rise.
// They are never high together.
interface sw_reg_loader_if #(
  parameter int DW   = 8,
  parameter int NCH  = 4,
  parameter int SELW = 2
);
  logic [SELW+DW-1:0] sw;
  logic [2:0]         key;
  logic [NCH*DW-1:0]  q;
  logic               upd;
  logic [SELW-1:0]    upd_ch;
  logic               err;

  modport master (output sw, key, input q, upd, upd_ch, err);
  modport slave  (input sw, key, output q, upd, upd_ch, err);
endinterface

// File: rtl/sw_reg_loader.sv
// sw_reg_loader
// Captures a switch data word into one of NCH registers chosen by the
// selector switches. Pushbuttons are synchronised, debounced per key and
// edge-detected. Each debounced press performs one load, increment or
// decrement on the selected channel.
// Ports:
//   clk  : system clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : sw_reg_loader_if slave (sw, key in; q, upd, upd_ch, err out)
module sw_reg_loader #(
  parameter int DW      = 8,
  parameter int NCH     = 4,
  parameter int SELW    = 2,
  parameter int DEB_CYC = 16
) (
  input  logic            clk,
  input  logic            RST,
  sw_reg_loader_if.slave  bus
);

  localparam int CW   = $clog2(DEB_CYC + 1);
  localparam int NSEL = 2 ** SELW;
  localparam int SW_W = SELW + DW;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_INC  = 2'd2,
    ACT_DEC  = 2'd3
  } act_e;

  // Two-flop synchronisers. Keys reset high (released).
  logic [SW_W-1:0] sw_m_q, sw_s_q;
  logic [2:0]      key_m_q, key_s_q;

  // Debounce state.
  logic [2:0]          db_q, db_d;
  logic [2:0][CW-1:0]  cnt_q, cnt_d;
  logic [2:0]          press;

  // Channel registers and status.
  logic [NCH-1:0][DW-1:0] q_q, q_d;
  logic                   upd_q, upd_d;
  logic [SELW-1:0]        upd_ch_q, upd_ch_d;
  logic                   err_q, err_d;

  logic [SELW-1:0] sel;
  logic [DW-1:0]   dat;
  logic [NSEL-1:0] ch_valid;
  act_e            act;

  assign sel = sw_s_q[SW_W-1:DW];
  assign dat = sw_s_q[DW-1:0];

  // Debounce: a key must disagree with its debounced state for DEB_CYC
  // consecutive samples before the debounced state follows it. A press is
  // the 1->0 flip of the debounced state, reported on the same edge.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    press = '0;
    for (int k = 0; k < 3; k++) begin
      if (key_s_q[k] != db_q[k]) begin
        if (cnt_q[k] == CW'(DEB_CYC - 1)) begin
          db_d[k]  = key_s_q[k];
          cnt_d[k] = '0;
          press[k] = ~key_s_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
  end

  // Load beats increment beats decrement; losers on the same edge are lost.
  always_comb begin
    act = ACT_NONE;
    if (press[0])      act = ACT_LOAD;
    else if (press[1]) act = ACT_INC;
    else if (press[2]) act = ACT_DEC;
  end

  // Selector codes at or above NCH have no register behind them.
  always_comb begin
    ch_valid = '0;
    for (int i = 0; i < NSEL; i++) begin
      ch_valid[i] = (i < NCH);
    end
  end

  always_comb begin
    q_d      = q_q;
    upd_d    = 1'b0;
    upd_ch_d = upd_ch_q;
    err_d    = 1'b0;
    if (act != ACT_NONE) begin
      if (ch_valid[sel]) begin
        upd_d    = 1'b1;
        upd_ch_d = sel;
        for (int i = 0; i < NCH; i++) begin
          if (sel == SELW'(i)) begin
            case (act)
              ACT_LOAD: q_d[i] = dat;
              ACT_INC:  q_d[i] = q_q[i] + DW'(1);
              ACT_DEC:  q_d[i] = q_q[i] - DW'(1);
              default:  q_d[i] = q_q[i];
            endcase
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sw_m_q   <= '0;
      sw_s_q   <= '0;
      key_m_q  <= 3'b111;
      key_s_q  <= 3'b111;
      db_q     <= 3'b111;
      cnt_q    <= '0;
      q_q      <= '0;
      upd_q    <= 1'b0;
      upd_ch_q <= '0;
      err_q    <= 1'b0;
    end else begin
      sw_m_q   <= bus.sw;
      sw_s_q   <= sw_m_q;
      key_m_q  <= bus.key;
      key_s_q  <= key_m_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      upd_q    <= upd_d;
      upd_ch_q <= upd_ch_d;
      err_q    <= err_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.upd    = upd_q;
  assign bus.upd_ch = upd_ch_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sw_reg_loader.sv
module tb_sw_reg_loader;

  logic clk;
  logic RST;

  sw_reg_loader_if #(.DW(8), .NCH(4), .SELW(2)) bus4 ();
  sw_reg_loader_if #(.DW(8), .NCH(3), .SELW(2)) bus3 ();

  sw_reg_loader #(.DW(8), .NCH(4), .SELW(2), .DEB_CYC(4)) u_dut4 (
    .clk (clk),
    .RST (RST),
    .bus (bus4)
  );

  sw_reg_loader #(.DW(8), .NCH(3), .SELW(2), .DEB_CYC(4)) u_dut3 (
    .clk (clk),
    .RST (RST),
    .bus (bus3)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt4 = 0;
  int upd_cnt3 = 0;
  int err_cnt3 = 0;
  logic [9:0] exp_q[$];   // {channel, value} expected per upd pulse of dut4

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] ch4(input logic [1:0] c);
    return bus4.q[c*8 +: 8];
  endfunction

  // Every upd pulse of dut4 must match the next queued expectation.
  logic [9:0] mon_e;
  always @(negedge clk) begin
    if (!RST) begin
      if (bus4.upd === 1'b1) begin
        upd_cnt4++;
        check_eq("upd4_vs_err4", bus4.err, 0);
        if (exp_q.size() == 0) begin
          check_eq("upd4_unexpected", bus4.upd, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("upd4_ch", bus4.upd_ch, mon_e[9:8]);
          check_eq("upd4_val", ch4(mon_e[9:8]), mon_e[7:0]);
        end
      end
      if (bus3.upd === 1'b1) begin
        upd_cnt3++;
        check_eq("upd3_vs_err3", bus3.err, 0);
      end
      if (bus3.err === 1'b1) err_cnt3++;
    end
  end

  // ---------------- driver ----------------
  // Drive select/data and the key pattern just after an edge, hold the keys
  // for 'hold' edges, then release and let the release debounce settle.
  task automatic press4(input logic [2:0] key_val, input logic [1:0] sel,
                        input logic [7:0] d, input int hold);
    bus4.sw  = {sel, d};
    bus4.key = key_val;
    repeat (hold) @(posedge clk);
    #1 bus4.key = 3'b111;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST      = 1'b1;
    bus4.sw  = '0;
    bus4.key = 3'b111;
    bus3.sw  = '0;
    bus3.key = 3'b111;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_q4",      bus4.q, 0);
    check_eq("rst_upd4",    bus4.upd, 0);
    check_eq("rst_updch4",  bus4.upd_ch, 0);
    check_eq("rst_err4",    bus4.err, 0);
    check_eq("rst_q3",      bus3.q, 0);
    check_eq("rst_err3",    bus3.err, 0);
    @(posedge clk);
    #1 RST = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: load ch1 = A5, event on edge 6 after key falls
    bus4.sw  = {2'b01, 8'hA5};
    bus4.key = 3'b110;
    exp_q.push_back({2'b01, 8'hA5});
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("t1_upd_e5", bus4.upd, 0);
    check_eq("t1_q_e5",   ch4(2'd1), 8'h00);
    @(posedge clk);
    @(negedge clk);
    check_eq("t1_upd_e6",   bus4.upd, 1);
    check_eq("t1_q_e6",     ch4(2'd1), 8'hA5);
    check_eq("t1_updch_e6", bus4.upd_ch, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("t1_upd_e7", bus4.upd, 0);
    repeat (13) @(posedge clk);
    #1 bus4.key = 3'b111;
    repeat (12) @(posedge clk);
    #1;
    check_eq("t1_upd_count", upd_cnt4, 1);
    check_eq("t1_ch0", ch4(2'd0), 8'h00);
    check_eq("t1_ch2", ch4(2'd2), 8'h00);
    check_eq("t1_ch3", ch4(2'd3), 8'h00);

    // 2: glitch of 3 cycles rejected, 4 cycles accepted
    press4(3'b110, 2'd1, 8'h3C, 3);
    check_eq("t2_glitch_q",   ch4(2'd1), 8'hA5);
    check_eq("t2_glitch_cnt", upd_cnt4, 1);
    exp_q.push_back({2'b01, 8'h3C});
    press4(3'b110, 2'd1, 8'h3C, 4);
    check_eq("t2_min_q",   ch4(2'd1), 8'h3C);
    check_eq("t2_min_cnt", upd_cnt4, 2);

    // 3: wrap on increment and decrement
    exp_q.push_back({2'b10, 8'hFF});
    press4(3'b110, 2'd2, 8'hFF, 8);
    check_eq("t3_load_ff", ch4(2'd2), 8'hFF);
    exp_q.push_back({2'b10, 8'h00});
    press4(3'b101, 2'd2, 8'h55, 8);
    check_eq("t3_inc_wrap", ch4(2'd2), 8'h00);
    exp_q.push_back({2'b10, 8'hFF});
    press4(3'b011, 2'd2, 8'h55, 8);
    check_eq("t3_dec_wrap", ch4(2'd2), 8'hFF);
    exp_q.push_back({2'b11, 8'hFF});
    press4(3'b011, 2'd3, 8'h55, 8);
    check_eq("t3_dec_ch3", ch4(2'd3), 8'hFF);
    check_eq("t3_cnt", upd_cnt4, 6);

    // 4: simultaneous load + increment, load wins, no later increment
    exp_q.push_back({2'b00, 8'h05});
    press4(3'b110, 2'd0, 8'h05, 8);
    check_eq("t4_pre", ch4(2'd0), 8'h05);
    exp_q.push_back({2'b00, 8'h10});
    press4(3'b100, 2'd0, 8'h10, 20);
    check_eq("t4_q",   ch4(2'd0), 8'h10);
    check_eq("t4_cnt", upd_cnt4, 8);

    // 5: out-of-range selector on the 3-channel instance
    bus3.sw  = {2'd2, 8'h42};
    bus3.key = 3'b110;
    repeat (8) @(posedge clk);
    #1 bus3.key = 3'b111;
    repeat (12) @(posedge clk);
    #1;
    check_eq("t5_pre_q",     bus3.q, 24'h420000);
    check_eq("t5_pre_updch", bus3.upd_ch, 2);
    bus3.sw  = {2'd3, 8'h99};
    bus3.key = 3'b110;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("t5_err_e5", bus3.err, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_err_e6", bus3.err, 1);
    check_eq("t5_upd_e6", bus3.upd, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_err_e7", bus3.err, 0);
    @(posedge clk);
    #1 bus3.key = 3'b111;
    repeat (12) @(posedge clk);
    #1;
    check_eq("t5_err_cnt", err_cnt3, 1);
    check_eq("t5_upd_cnt", upd_cnt3, 1);
    check_eq("t5_updch",   bus3.upd_ch, 2);
    check_eq("t5_q",       bus3.q, 24'h420000);

    // 6: reset at debounce count 2, key held through release
    bus4.sw  = {2'b01, 8'h99};
    bus4.key = 3'b110;
    repeat (4) @(posedge clk);
    #1 RST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_rst_q4",     bus4.q, 0);
    check_eq("t6_rst_upd4",   bus4.upd, 0);
    check_eq("t6_rst_updch4", bus4.upd_ch, 0);
    check_eq("t6_rst_err4",   bus4.err, 0);
    check_eq("t6_rst_q3",     bus3.q, 0);
    RST = 1'b0;
    exp_q.push_back({2'b01, 8'h99});
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("t6_upd_r5", bus4.upd, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t6_upd_r6", bus4.upd, 1);
    check_eq("t6_q_r6",   ch4(2'd1), 8'h99);
    @(posedge clk);
    #1 bus4.key = 3'b111;
    repeat (12) @(posedge clk);
    #1;

    check_eq("final_cnt4",    upd_cnt4, 9);
    check_eq("final_exp_q",   exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
